// File: rtl/serial_bit_source_if.sv
// Word-side handshake bundle for serial_bit_source: the producer drives
// word_in, word_len and word_valid; the serialiser answers with word_ready.
interface serial_bit_source_if #(
    parameter int WIDTH = 14,
    parameter int LW    = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] word_in;
    logic [LW-1:0]    word_len;
    logic             word_valid;
    logic             word_ready;

    modport master (output word_in, output word_len, output word_valid, input word_ready);
    modport slave  (input word_in, input word_len, input word_valid, output word_ready);
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: variable-length words in over valid/ready,
// MSB-first continuous bit stream out, with a one-word holding register.
module serial_bit_source #(
    parameter int WIDTH = 14,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_bit_source_if.slave  word,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                underrun
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic [LW-1:0]    sh_cnt_reg, sh_cnt_next;
    logic [WIDTH-1:0] hd_reg, hd_next;
    logic [LW-1:0]    hd_len_reg, hd_len_next;
    logic             hd_full_reg, hd_full_next;
    logic             bit_out_reg, bit_out_next;
    logic             bit_valid_reg, bit_valid_next;
    logic             underrun_reg, underrun_next;

    logic [LW-1:0]    in_len;
    logic [WIDTH-1:0] in_aligned;
    logic             handshake;
    logic             refill;

    assign word.word_ready = !hd_full_reg;
    assign handshake       = word.word_valid && !hd_full_reg;
    assign refill          = (state_reg == IDLE) || (sh_cnt_reg == LW'(1));

    // Words are stored left-aligned so the next bit is always sh[WIDTH-1].
    always_comb begin
        if ((word.word_len == '0) || (word.word_len > LW'(WIDTH)))
            in_len = LW'(WIDTH);
        else
            in_len = word.word_len;
        in_aligned = word.word_in << (LW'(WIDTH) - in_len);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            sh_reg        <= '0;
            sh_cnt_reg    <= '0;
            hd_reg        <= '0;
            hd_len_reg    <= '0;
            hd_full_reg   <= 1'b0;
            bit_out_reg   <= 1'b0;
            bit_valid_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sh_reg        <= sh_next;
            sh_cnt_reg    <= sh_cnt_next;
            hd_reg        <= hd_next;
            hd_len_reg    <= hd_len_next;
            hd_full_reg   <= hd_full_next;
            bit_out_reg   <= bit_out_next;
            bit_valid_reg <= bit_valid_next;
            underrun_reg  <= underrun_next;
        end
    end

    always_comb begin
        sh_next        = sh_reg;
        sh_cnt_next    = sh_cnt_reg;
        hd_next        = hd_reg;
        hd_len_next    = hd_len_reg;
        hd_full_next   = hd_full_reg;
        bit_out_next   = 1'b0;
        bit_valid_next = 1'b0;

        case (state_reg)
            SHIFT: begin
                bit_out_next   = sh_reg[WIDTH-1];
                bit_valid_next = 1'b1;
                sh_next        = sh_reg << 1;
                sh_cnt_next    = sh_cnt_reg - LW'(1);
            end
            default: ;
        endcase

        // Holding register has priority on refill; a handshake can only
        // land directly in the shifter when hd is empty.
        if (refill) begin
            if (hd_full_reg) begin
                sh_next      = hd_reg;
                sh_cnt_next  = hd_len_reg;
                hd_full_next = 1'b0;
            end else if (handshake) begin
                sh_next     = in_aligned;
                sh_cnt_next = in_len;
            end
        end

        if (handshake && !refill) begin
            hd_next      = in_aligned;
            hd_len_next  = in_len;
            hd_full_next = 1'b1;
        end

        state_next    = (sh_cnt_next != '0) ? SHIFT : IDLE;
        underrun_next = bit_valid_reg && !bit_valid_next;
    end

    assign bit_out   = bit_out_reg;
    assign bit_valid = bit_valid_reg;
    assign underrun  = underrun_reg;
endmodule
